// File: rtl/jam_perm_solver_pkg.sv
// Shared types and elaboration helpers for the job-assignment permutation solver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package jam_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEARCH,
        S_OUT
    } state_t;

    // n! evaluated at elaboration time (search length in cycles).
    function automatic int fact(input int n);
        int f;
        f = 1;
        for (int i = 2; i <= n; i++) begin
            f = f * i;
        end
        return f;
    endfunction

    // Bits needed to index n items; never less than 1.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Legal parameter set: N in 2..8, job field holds an index, cost
    // accumulator holds N maximal entries without wrapping.
    function automatic bit params_ok(input int n, input int cw, input int jw, input int ow);
        return (n >= 2) && (n <= 8) && (cw >= 1) &&
               (jw >= idx_w(n)) && (ow >= cw + idx_w(n));
    endfunction

endpackage

// File: rtl/jam_perm_solver_next_perm.sv
// Lexicographic successor of a permutation, plus a flag when the input is the descending (final) one.
// Latency: purely combinational.
// Backpressure: none.
// Ports: i_perm (current permutation, element w at i_perm[w]), o_next (successor), o_is_last.
module jam_next_perm
    import jam_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0][idx_w(N)-1:0] i_perm,
    output logic [N-1:0][idx_w(N)-1:0] o_next,
    output logic                       o_is_last
);
    localparam int PW = idx_w(N);

    logic [PW-1:0]        w_i;
    logic [PW-1:0]        w_j;
    logic                 w_found;
    logic [N-1:0][PW-1:0] w_swp;

    always_comb begin
        // Pivot: largest i with p[i] < p[i+1]; none means descending order.
        w_i     = '0;
        w_found = 1'b0;
        for (int a = 0; a < N - 1; a++) begin
            if (i_perm[a] < i_perm[a+1]) begin
                w_i     = PW'(a);
                w_found = 1'b1;
            end
        end

        // Largest j beyond the pivot holding a larger value.
        w_j = w_i;
        for (int b = 0; b < N; b++) begin
            if ((PW'(b) > w_i) && (i_perm[b] > i_perm[w_i])) begin
                w_j = PW'(b);
            end
        end

        w_swp      = i_perm;
        w_swp[w_i] = i_perm[w_j];
        w_swp[w_j] = i_perm[w_i];

        // Reverse the suffix after the pivot: position b takes N+i-b.
        o_next = w_swp;
        for (int b = 0; b < N; b++) begin
            if (PW'(b) > w_i) begin
                o_next[b] = w_swp[PW'(N + int'(w_i) - b)];
            end
        end
    end

    assign o_is_last = ~w_found;

endmodule

// File: rtl/jam_perm_solver.sv
// Minimum-cost N x N job assignment by exhaustive lexicographic permutation search.
// Latency: last matrix sample at cycle t -> search t+1..t+N!, out_valid t+N!+1..t+N!+N.
// Backpressure: none; in_valid accepted only in IDLE/LOAD, ignored during SEARCH/OUT.
// Ports: clk, rst_n (async active-low); in_valid/in_cost row-major matrix entries;
//        out_valid for N cycles, out_job = job of worker k, out_cost = minimum total.
module jam_perm_solver
    import jam_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = 7,
    parameter int JW = 4,
    parameter int OW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [CW-1:0] in_cost,
    output logic          out_valid,
    output logic [JW-1:0] out_job,
    output logic [OW-1:0] out_cost
);
    localparam int PW = idx_w(N);
    localparam int NN = N * N;
    localparam int LW = idx_w(NN);

    if (!params_ok(N, CW, JW, OW)) begin : g_bad_params
        $error("jam_perm_solver: illegal N/CW/JW/OW combination");
    end

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_cost [NN];
    logic [LW-1:0]        r_cnt;
    logic [N-1:0][PW-1:0] r_perm;
    logic [N-1:0][PW-1:0] r_best_perm;
    logic [N-1:0][PW-1:0] w_perm_nxt;
    logic [N-1:0][PW-1:0] w_ident;
    logic [OW-1:0]        r_best_cost;
    logic [OW-1:0]        w_sum;
    logic                 r_first;
    logic                 w_is_last;
    logic [PW-1:0]        r_k;

    jam_next_perm #(.N(N)) u_next_perm (
        .i_perm    (r_perm),
        .o_next    (w_perm_nxt),
        .o_is_last (w_is_last)
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_ident[i] = PW'(i);
        end
    end

    // Cost of the permutation under evaluation: sum of cost[w][perm[w]].
    always_comb begin
        w_sum = '0;
        for (int w = 0; w < N; w++) begin
            w_sum = w_sum + OW'(r_cost[LW'(w * N) + LW'(r_perm[w])]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (in_valid) w_state_nxt = S_LOAD;
            S_LOAD: begin
                if (!in_valid)                  w_state_nxt = S_IDLE;
                else if (r_cnt == LW'(NN - 1))  w_state_nxt = S_SEARCH;
            end
            S_SEARCH: if (w_is_last) w_state_nxt = S_OUT;
            S_OUT:    if (r_k == PW'(N - 1)) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NN; i++) begin
                r_cost[i] <= '0;
            end
            r_cnt       <= '0;
            r_perm      <= '0;
            r_best_perm <= '0;
            r_best_cost <= '0;
            r_first     <= 1'b0;
            r_k         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_cost[0] <= in_cost;
                        r_cnt     <= LW'(1);
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        r_cost[r_cnt] <= in_cost;
                        r_cnt         <= r_cnt + 1'b1;
                        // Primed on every load beat so the search always starts clean.
                        r_perm        <= w_ident;
                        r_first       <= 1'b1;
                    end
                end
                S_SEARCH: begin
                    r_first <= 1'b0;
                    // Strict compare keeps the lexicographically first among ties.
                    if (r_first || (w_sum < r_best_cost)) begin
                        r_best_cost <= w_sum;
                        r_best_perm <= r_perm;
                    end
                    r_perm <= w_perm_nxt;
                end
                S_OUT: begin
                    r_k <= (r_k == PW'(N - 1)) ? '0 : r_k + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs derive straight from state so reset clears them asynchronously.
    assign out_valid = (r_state == S_OUT);
    assign out_job   = out_valid ? JW'(r_best_perm[r_k]) : '0;
    assign out_cost  = out_valid ? r_best_cost : '0;

endmodule

// File: tb/tb_jam_perm_solver.sv
// Self-checking bench: N=4 table-driven matrices plus abort/reset/ignore sequences, and one N=8 run.
// Latency: checks first out_valid at last-sample + N! + 1.
// Backpressure: none exercised beyond in_valid being ignored outside IDLE/LOAD.
module tb_jam_perm_solver;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int t_last = 0;

    logic       in_valid4;
    logic [6:0] in_cost4;
    logic       out_valid4;
    logic [3:0] out_job4;
    logic [9:0] out_cost4;

    logic       in_valid8;
    logic [6:0] in_cost8;
    logic       out_valid8;
    logic [3:0] out_job8;
    logic [9:0] out_cost8;

    jam_perm_solver #(.N(4), .CW(7), .JW(4), .OW(10)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_cost   (in_cost4),
        .out_valid (out_valid4),
        .out_job   (out_job4),
        .out_cost  (out_cost4)
    );

    jam_perm_solver #(.N(8), .CW(7), .JW(4), .OW(10)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_cost   (in_cost8),
        .out_valid (out_valid8),
        .out_job   (out_job8),
        .out_cost  (out_cost8)
    );

    typedef struct {
        int          kind;   // 0 diag, 1 anti-diag, 2 shift-by-one, 3 swap of workers 0/1
        int          a;      // value on the selected cells
        int          b;      // value elsewhere
        logic [15:0] ej;     // expected job of worker k in bits [4k+:4]
        int          ecost;
    } vec_t;

    vec_t vecs[5];
    int   mat4[16];
    int   mat8[64];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic build4(input int kind, input int a, input int b);
        bit hit;
        for (int w = 0; w < 4; w++) begin
            for (int j = 0; j < 4; j++) begin
                case (kind)
                    0:       hit = (j == w);
                    1:       hit = (j == 3 - w);
                    2:       hit = (j == (w + 1) % 4);
                    default: hit = ((w == 0) && (j == 1)) || ((w == 1) && (j == 0));
                endcase
                mat4[w*4+j] = hit ? a : b;
            end
        end
    endtask

    // Called at a negedge; returns at a negedge with in_valid low.
    task automatic load4(input int n);
        for (int k = 0; k < n; k++) begin
            in_valid4 = 1'b1;
            in_cost4  = 7'(mat4[k]);
            @(negedge clk);
        end
        t_last    = cyc - 1;
        in_valid4 = 1'b0;
        in_cost4  = '0;
    endtask

    task automatic collect4(input string nm, input logic [15:0] ej, input int ecost);
        int waited;
        waited = 0;
        while (!out_valid4 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk({nm, "_seen"}, int'(out_valid4), 1);
        if (out_valid4) begin
            chk({nm, "_latency"}, cyc - t_last, 25);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("%s_valid%0d", nm, k), int'(out_valid4), 1);
                chk($sformatf("%s_job%0d", nm, k), int'(out_job4), int'(ej[4*k +: 4]));
                chk($sformatf("%s_cost%0d", nm, k), int'(out_cost4), ecost);
                @(negedge clk);
            end
            chk({nm, "_end_valid"}, int'(out_valid4), 0);
            chk({nm, "_end_job"}, int'(out_job4), 0);
            chk({nm, "_end_cost"}, int'(out_cost4), 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int nseen;
        logic [31:0] ej8;

        vecs[0] = '{0, 1,  10,  16'h3210, 4};
        vecs[1] = '{0, 5,  5,   16'h3210, 20};
        vecs[2] = '{1, 0,  127, 16'h0123, 0};
        vecs[3] = '{2, 2,  50,  16'h0321, 8};
        vecs[4] = '{3, 0,  9,   16'h3201, 18};

        rst_n     = 1'b0;
        in_valid4 = 1'b0;
        in_cost4  = '0;
        in_valid8 = 1'b0;
        in_cost8  = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid4", int'(out_valid4), 0);
        chk("rst_job4",   int'(out_job4),   0);
        chk("rst_cost4",  int'(out_cost4),  0);
        chk("rst_valid8", int'(out_valid8), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors, back to back.
        for (int v = 0; v < 5; v++) begin
            build4(vecs[v].kind, vecs[v].a, vecs[v].b);
            load4(16);
            collect4($sformatf("vec%0d", v), vecs[v].ej, vecs[v].ecost);
        end

        // Abort after 5 samples: nothing must come out.
        build4(0, 1, 10);
        load4(5);
        nseen = 0;
        repeat (60) begin
            @(negedge clk);
            if (out_valid4) nseen++;
        end
        chk("abort_no_out", nseen, 0);
        load4(16);
        collect4("after_abort", 16'h3210, 4);

        // Reset in the middle of SEARCH, then a clean solve.
        build4(0, 5, 5);
        load4(16);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_search_valid", int'(out_valid4), 0);
        chk("rst_search_job",   int'(out_job4),   0);
        chk("rst_search_cost",  int'(out_cost4),  0);
        @(negedge clk);
        rst_n = 1'b1;
        build4(0, 1, 10);
        load4(16);
        collect4("after_rst_search", 16'h3210, 4);

        // in_valid noise during SEARCH is ignored; reset during OUT clears outputs at once.
        build4(2, 2, 50);
        load4(16);
        repeat (10) begin
            in_valid4 = 1'b1;
            in_cost4  = '0;
            @(negedge clk);
        end
        in_valid4 = 1'b0;
        nseen = 0;
        while (!out_valid4 && nseen < 100) begin
            @(negedge clk);
            nseen++;
        end
        chk("ign_seen", int'(out_valid4), 1);
        chk("ign_job0", int'(out_job4), 1);
        chk("ign_cost", int'(out_cost4), 8);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid4), 0);
        chk("rst_out_job",   int'(out_job4),   0);
        chk("rst_out_cost",  int'(out_cost4),  0);
        @(negedge clk);
        rst_n = 1'b1;
        build4(1, 0, 127);
        load4(16);
        collect4("after_rst_out", 16'h0123, 0);

        // N=8: cost[w][j] = (w+j)%8, unique zero-cost assignment 0,7,6,...,1.
        for (int w = 0; w < 8; w++) begin
            for (int j = 0; j < 8; j++) begin
                mat8[w*8+j] = (w + j) % 8;
            end
        end
        ej8 = 32'h1234_5670;
        for (int k = 0; k < 64; k++) begin
            in_valid8 = 1'b1;
            in_cost8  = 7'(mat8[k]);
            @(negedge clk);
        end
        t_last    = cyc - 1;
        in_valid8 = 1'b0;
        in_cost8  = '0;
        nseen = 0;
        while (!out_valid8 && nseen < 41000) begin
            @(negedge clk);
            nseen++;
        end
        chk("n8_seen", int'(out_valid8), 1);
        if (out_valid8) begin
            chk("n8_latency", cyc - t_last, 40321);
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("n8_job%0d", k), int'(out_job8), int'(ej8[4*k +: 4]));
                chk($sformatf("n8_cost%0d", k), int'(out_cost8), 0);
                @(negedge clk);
            end
            chk("n8_end_valid", int'(out_valid8), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jam_perm_solver.md
Name: jam_perm_solver

Overview:
- Parametrised job-assignment solver: loads an N×N cost matrix (worker rows, job columns), finds the minimum total-cost assignment of N jobs to N workers, and streams the result.
- Exhaustive lexicographic permutation search: one candidate assignment evaluated per cycle.
- Successor to the fixed 8×8 assignment front-end; adds N/width generalisation, a full result path and abort handling.

Parameters:
- N, 8, matrix dimension (workers = jobs); legal range 2..8
- CW, 7, cost entry width (unsigned)
- JW, 4, out_job width; must be ≥ clog2(N)
- OW, 10, out_cost width; must be ≥ CW + clog2(N)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  qualifies in_cost
- in_cost  in  CW  matrix entry, row-major: worker 0 jobs 0..N-1, then worker 1, …
- out_valid  out  1  high for exactly N consecutive cycles per solved matrix
- out_job  out  JW  job index (0..N-1) assigned to worker k in the k-th out_valid cycle
- out_cost  out  OW  minimum total cost, constant across all N out_valid cycles

Behaviour:
- Reset (asynchronous): out_valid=0, out_job=0, out_cost=0, state=IDLE, counters/perm/best cleared. Reset mid-operation discards everything.
- out_job and out_cost are 0 whenever out_valid=0.
- IDLE:
  - in_valid=1 captures entry (0,0) and moves to LOAD with load count=1.
- LOAD:
  - Each in_valid cycle stores the next entry.
  - After N*N entries, go to SEARCH with perm = identity (0,1,…,N-1).
  - in_valid=0 before N*N entries → abort to IDLE. No output, matrix discarded.
- SEARCH: one permutation per cycle, N! cycles in total.
  - Cost = sum over w of cost[w][perm[w]], computed combinationally at OW bits; no overflow by parameter rule.
  - First permutation loads best_cost/best_perm unconditionally.
  - Later permutations replace them only if strictly less, so ties keep the lexicographically first.
  - Next permutation uses the standard algorithm: largest i with p[i]<p[i+1]; largest j>i with p[j]>p[i]; swap; reverse the suffix after i.
  - After the descending permutation (N-1,…,0) is evaluated, go to OUT.
- OUT: N cycles; out_valid=1, out_job=best_perm[k] for k=0..N-1, out_cost=best_cost. Then IDLE.
- in_valid during SEARCH/OUT is ignored. A new matrix is accepted from IDLE only; it may begin the cycle after the last out_valid.
- Latency: if the last input sample is at cycle t, SEARCH occupies t+1..t+N! and out_valid is high at t+N!+1..t+N!+N.
- Back-to-back matrices: each is solved independently, with no state carried over.

Decomposition:
- Package jam_pkg:
  - state enum {S_IDLE, S_LOAD, S_SEARCH, S_OUT}
  - constant function fact(n)
  - width helper functions
  - legal-range checks for N, JW, OW (elaboration assertions)
- Sub-module jam_next_perm (parametrised by N): purely combinational, maps perm → next_perm plus an is_last flag (perm is descending).
- Top module holds the FSM, cost matrix, cost adder tree, best registers and output sequencer.

Test Plan:
- N=4, CW=7: diagonal entries 1, all others 10 → out_job 0,1,2,3; out_cost 4; out_valid 4 cycles starting t+25.
- N=4: all entries 5 → tie; out_job 0,1,2,3 (first lexicographic); out_cost 20.
- N=4: anti-diagonal 0, all others 127 → out_job 3,2,1,0 (last permutation evaluated); out_cost 0.
- N=8 default: all entries 127 → out_cost 1016, out_job 0..7; out_valid at t+40321..t+40328. Then a second matrix with cost[w][j]=(w+j)%8 → out_cost 0 with first-lexicographic zero-cost permutation (0,7,6,5,4,3,2,1).
- N=4: in_valid dropped after 5 samples → no out_valid ever. A following full load solves normally, with result identical to the first scenario when the same matrix is used.
- N=4: rst_n asserted during SEARCH → all outputs 0 immediately (asynchronous). After release, a full load produces correct results with no stale best_cost.
